// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu between two requesters.
// Define ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins ties).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  output logic             resp_valid0,
  output logic             resp_valid1,
  input  logic             resp_ready0,
  input  logic             resp_ready1,
  output logic [WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   grant0;
  logic   grant1;
  logic   acc0;
  logic   acc1;
  logic   rsp_done;

`ifdef ALU_ARB_FIXED_PRI_EN
  assign grant0 = req_valid0;
  assign grant1 = req_valid1 & ~req_valid0;
`else
  // last_grant=1 after reset so requester 0 wins the first tie
  logic last_grant;

  assign grant0 = req_valid0 & (~req_valid1 | last_grant);
  assign grant1 = req_valid1 & (~req_valid0 | ~last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (acc0) begin
      last_grant <= 1'b0;
    end else if (acc1) begin
      last_grant <= 1'b1;
    end
  end
`endif

  assign acc0     = req_valid0 & req_ready0;
  assign acc1     = req_valid1 & req_ready1;
  assign rsp_done = owner ? resp_ready1 : resp_ready0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (acc0 | acc1) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    req_ready0 = (state == IDLE) & grant0;
    req_ready1 = (state == IDLE) & grant1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      owner       <= 1'b0;
      resp_data   <= '0;
      resp_valid0 <= 1'b0;
      resp_valid1 <= 1'b0;
    end else begin
      unique case (1'b1)
        acc0: begin
          alu_a  <= req_a0;
          alu_b  <= req_b0;
          alu_op <= req_op0;
          owner  <= 1'b0;
        end
        acc1: begin
          alu_a  <= req_a1;
          alu_b  <= req_b1;
          alu_op <= req_op1;
          owner  <= 1'b1;
        end
        default: ;
      endcase
      if (state == EXEC) begin
        resp_data   <= alu_out;
        resp_valid0 <= ~owner;
        resp_valid1 <= owner;
      end else if (state == RESP && rsp_done) begin
        resp_valid0 <= 1'b0;
        resp_valid1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with an external ADD/SUB alu model.
// Tie ordering expectations follow ALU_ARB_FIXED_PRI_EN when defined.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_valid0;
  logic        req_valid1;
  logic        req_ready0;
  logic        req_ready1;
  logic [31:0] req_a0;
  logic [31:0] req_a1;
  logic [31:0] req_b0;
  logic [31:0] req_b1;
  logic [4:0]  req_op0;
  logic [4:0]  req_op1;
  logic        resp_valid0;
  logic        resp_valid1;
  logic        resp_ready0;
  logic        resp_ready1;
  logic [31:0] resp_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_out;
  logic        busy;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];
  int  n_cmp;
  int  n_err;
  int  cyc;

  alu_arbiter #(.WIDTH(32), .OPW(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid0(req_valid0),
    .req_valid1(req_valid1),
    .req_ready0(req_ready0),
    .req_ready1(req_ready1),
    .req_a0(req_a0),
    .req_a1(req_a1),
    .req_b0(req_b0),
    .req_b1(req_b1),
    .req_op0(req_op0),
    .req_op1(req_op1),
    .resp_valid0(resp_valid0),
    .resp_valid1(resp_valid1),
    .resp_ready0(resp_ready0),
    .resp_ready1(resp_ready1),
    .resp_data(resp_data),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_out(alu_out),
    .busy(busy)
  );

  assign alu_out = (alu_op == 5'd1) ? alu_a - alu_b : alu_a + alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  op
  );
    return (op == 5'd1) ? a - b : a + b;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // handshakes complete at the next posedge; sample them mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid0 && req_ready0)
        sb.push_back('{1'b0, model(req_a0, req_b0, req_op0)});
      if (req_valid1 && req_ready1)
        sb.push_back('{1'b1, model(req_a1, req_b1, req_op1)});
      chk("onehot", 32'(resp_valid0 & resp_valid1), 0);
      if ((resp_valid0 && resp_ready0) || (resp_valid1 && resp_ready1)) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_id", 32'(resp_valid1), 32'(e.id));
          chk("sb_data", resp_data, e.data);
        end
      end
    end
  end

  task automatic set_req(
    input int          id,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  op
  );
    if (id == 0) begin
      req_valid0 = 1'b1; req_a0 = a; req_b0 = b; req_op0 = op;
    end else begin
      req_valid1 = 1'b1; req_a1 = a; req_b1 = b; req_op1 = op;
    end
  endtask

  task automatic wait_ready(input int id, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = (id == 0) ? req_ready0 : req_ready1;
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic send(
    input int          id,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  op
  );
    set_req(id, a, b, op);
    wait_ready(id, "send_acc");
    @(posedge clk); #1;
    if (id == 0) req_valid0 = 1'b0;
    else req_valid1 = 1'b0;
  endtask

  task automatic serve_pending();
    logic r0;
    logic r1;
    for (int i = 0; i < 60; i++) begin
      if (!req_valid0 && !req_valid1) break;
      @(negedge clk);
      r0 = req_valid0 & req_ready0;
      r1 = req_valid1 & req_ready1;
      @(posedge clk); #1;
      if (r0) req_valid0 = 1'b0;
      if (r1) req_valid1 = 1'b0;
    end
    chk("drain", 32'(req_valid0 | req_valid1), 0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && sb.size() == 0 && !resp_valid0 && !resp_valid1;
    end
    chk("idle", 32'(ok), 1);
  endtask

  initial begin
    logic        r0;
    logic        r1;
    logic [31:0] ea;
    logic [31:0] eb;
    int          last_cyc;
    n_cmp = 0; n_err = 0; last_cyc = 0;
    rst_n = 1'b0;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_a0 = '0; req_b0 = '0; req_op0 = '0;
    req_a1 = '0; req_b1 = '0; req_op1 = '0;
    resp_ready0 = 1'b1; resp_ready1 = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rv0", 32'(resp_valid0), 0);
    chk("rst_rv1", 32'(resp_valid1), 0);
    chk("rst_data", resp_data, 0);
    chk("rst_alu_a", alu_a, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset in the middle of EXEC drops the op
    @(posedge clk); #1;
    set_req(0, 32'd9, 32'd1, 5'd0);
    wait_ready(0, "mid_acc");
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    chk("mid_alu_a", alu_a, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a", alu_a, 0);
    chk("mid_rst_b", alu_b, 0);
    chk("mid_rst_op", 32'(alu_op), 0);
    chk("mid_rst_data", resp_data, 0);
    chk("mid_rst_rv0", 32'(resp_valid0), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("mid_noresp", 32'(resp_valid0 | resp_valid1), 0);
    end

    // tie: req0 first, then req1 beats a fresh req0 (round-robin)
    @(posedge clk); #1;
    set_req(0, 32'd3, 32'd2, 5'd0);
    set_req(1, 32'd7, 32'd4, 5'd1);
    wait_ready(0, "tie1_acc");
    chk("tie1_r1", 32'(req_ready1), 0);
    @(posedge clk); #1;
    set_req(0, 32'd10, 32'd4, 5'd1);
    r0 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 30 && !(r0 | r1); i++) begin
      @(negedge clk);
      r0 = req_ready0;
      r1 = req_ready1;
    end
`ifdef ALU_ARB_FIXED_PRI_EN
    chk("tie2_r0", 32'(r0), 1);
    chk("tie2_r1", 32'(r1), 0);
`else
    chk("tie2_r0", 32'(r0), 0);
    chk("tie2_r1", 32'(r1), 1);
`endif
    @(posedge clk); #1;
    if (r0) req_valid0 = 1'b0;
    if (r1) req_valid1 = 1'b0;
    serve_pending();
    wait_idle();

    // single op latency: accept edge T -> resp_valid0 after T+1
    @(posedge clk); #1;
    send(0, 32'd3, 32'd2, 5'd0);
    chk("lat_t0", 32'(resp_valid0), 0);
    @(posedge clk); #1;
    chk("lat_t1_rv", 32'(resp_valid0), 1);
    chk("lat_t1_data", resp_data, 5);
    wait_idle();

    // backpressure holds the response and blocks new accepts
    @(posedge clk); #1;
    resp_ready0 = 1'b0;
    send(0, 32'd3, 32'd2, 5'd0);
    set_req(1, 32'd1, 32'd1, 5'd0);
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_rv0", 32'(resp_valid0), 1);
      chk("bp_data", resp_data, 5);
      chk("bp_rdy0", 32'(req_ready0), 0);
      chk("bp_rdy1", 32'(req_ready1), 0);
      chk("bp_busy", 32'(busy), 1);
    end
    @(posedge clk); #1;
    resp_ready0 = 1'b1;
    serve_pending();
    wait_idle();

    // stream on requester 1: one accept every 3 cycles
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      ea = 32'(100 + i);
      eb = 32'(i);
      set_req(1, ea, eb, 5'(i % 2));
      wait_ready(1, "str_acc");
      if (i > 0) chk("str_gap", 32'(cyc - last_cyc), 3);
      last_cyc = cyc;
      @(posedge clk); #1;
      @(negedge clk);
      chk("str_a", alu_a, ea);
      chk("str_b", alu_b, eb);
      @(posedge clk); #1;
    end
    req_valid1 = 1'b0;
    wait_idle();

    // wrap-around result passes through unmodified
    @(posedge clk); #1;
    resp_ready0 = 1'b0;
    send(0, 32'hFFFF_FFFF, 32'd1, 5'd0);
    @(posedge clk); #1;
    chk("wrap_rv0", 32'(resp_valid0), 1);
    chk("wrap_data", resp_data, 32'h0000_0000);
    resp_ready0 = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
